// File: rtl/func_cbrt_if.sv
// Handshake bundle for the cube-root solver.
// Purpose: carries the start/busy/done handshake together with the y operand
//          and the x result between a requester and func_cbrt.
// Signals:
//   start  request pulse from the requester
//   y      signed y coordinate, captured by the solver when start is accepted
//   busy   high while a solve is in progress
//   done   one-cycle pulse marking x as newly valid
//   x      signed result, held until the next done
// Modports: master = requester side, slave = solver side.
interface func_cbrt_if #(
   parameter int CORDW = 8
);
   logic                    start;
   logic signed [CORDW-1:0] y;
   logic                    busy;
   logic                    done;
   logic signed [CORDW-1:0] x;

   modport master (
      output start,
      output y,
      input  busy,
      input  done,
      input  x
   );

   modport slave (
      input  start,
      input  y,
      output busy,
      output done,
      output x
   );
endinterface

// File: rtl/func_cbrt.sv
// Iterative signed cube-root solver for the maths demo.
// Purpose: returns x = sign(y) * floor(cbrt(|y| * Y_SCALE)), the point where the
//          cubed curve x^3 = Y_SCALE*y crosses a given y. The root is found by a
//          restoring bit-serial search, one trial bit per three-cycle iteration
//          (square, cube, compare), so no cycle chains two multiplications.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   func_cbrt_if.slave: start/y in, busy/done/x out
module func_cbrt #(
   parameter int CORDW   = 8,
   parameter int Y_SCALE = 16384
) (
   input logic        clk,
   input logic        rst,
   func_cbrt_if.slave bus
);

   localparam int MW = 3 * CORDW;
   localparam int SW = 2 * CORDW;
   localparam int IW = $clog2(CORDW);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SQ,
      CU,
      CMP
   } state_t;

   state_t                  state_q, state_d;
   logic signed [CORDW-1:0] y_q, y_d;
   logic signed [CORDW-1:0] x_q, x_d;
   logic [MW-1:0]           m_q, m_d;
   logic [MW-1:0]           cu_q, cu_d;
   logic [SW-1:0]           sq_q, sq_d;
   logic [CORDW-1:0]        root_q, root_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    neg_q, neg_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [CORDW:0]          yAbs;
   logic [CORDW-1:0]        trial;
   logic [CORDW-1:0]        rootFinal;

   // One extra bit on the magnitude keeps |-2^(CORDW-1)| representable.
   // The trial stays valid across SQ, CU and CMP because root and the bit
   // index only move on the CMP edge.
   always_comb begin
      yAbs      = y_q[CORDW-1] ? ({1'b0, ~y_q} + (CORDW+1)'(1)) : {1'b0, y_q};
      trial     = root_q | (CORDW'(1) << idx_q);
      rootFinal = (cu_q <= m_q) ? trial : root_q;
   end

   // State and datapath registers; reset abandons any solve in flight and
   // clears every register so no stale done can follow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         x_q     <= '0;
         m_q     <= '0;
         cu_q    <= '0;
         sq_q    <= '0;
         root_q  <= '0;
         idx_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         x_q     <= x_d;
         m_q     <= m_d;
         cu_q    <= cu_d;
         sq_q    <= sq_d;
         root_q  <= root_d;
         idx_q   <= idx_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state sequencing: a start outside IDLE is simply not looked at,
   // which is what makes it harmless while busy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = INIT;
         INIT:    state_d = SQ;
         SQ:      state_d = CU;
         CU:      state_d = CMP;
         CMP:     state_d = (idx_q == '0) ? IDLE : SQ;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and handshake outputs per state. The final CMP edge writes x
   // from the root including the last accepted trial bit, so the result does
   // not need an extra cycle.
   always_comb begin
      y_d    = y_q;
      x_d    = x_q;
      m_d    = m_q;
      cu_d   = cu_q;
      sq_d   = sq_q;
      root_d = root_q;
      idx_d  = idx_q;
      neg_d  = neg_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               y_d    = bus.y;
               busy_d = 1'b1;
            end
         end
         INIT: begin
            m_d    = MW'(yAbs) * MW'(Y_SCALE);
            neg_d  = y_q[CORDW-1];
            root_d = '0;
            idx_d  = IW'(CORDW - 1);
         end
         SQ: begin
            sq_d = SW'(trial) * SW'(trial);
         end
         CU: begin
            cu_d = MW'(sq_q) * MW'(trial);
         end
         CMP: begin
            root_d = rootFinal;
            if (idx_q == '0) begin
               x_d    = neg_q ? $signed(CORDW'(~rootFinal + CORDW'(1)))
                              : $signed(rootFinal);
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.x    = x_q;

endmodule
